// File: rtl/divider_pkg.sv
// Shared types and constants for the restoring divider.
// Build option DIVIDER_RADIX4_EN retires two quotient bits per CALC cycle.
package divider_pkg;

  localparam int BIT_DEF = 16;

`ifdef DIVIDER_RADIX4_EN
  localparam int STEPS_PER_CYCLE = 2;
`else
  localparam int STEPS_PER_CYCLE = 1;
`endif

  localparam int ITER_CNT = BIT_DEF / STEPS_PER_CYCLE;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  function automatic int iter_cnt(input int bit_w);
    return bit_w / STEPS_PER_CYCLE;
  endfunction

endpackage

// File: rtl/divider_step.sv
// One combinational restoring-division step.
// The trial value keeps the shifted-out MSB, so nothing is truncated.
module divider_step
  import divider_pkg::*;
#(
  parameter int W = BIT_DEF
) (
  input  logic [W-1:0] rem,
  input  logic         din_bit,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_next,
  output logic         q_bit
);

  logic [W:0] trial;
  logic [W:0] diff;

  always_comb begin
    trial    = {rem, din_bit};
    diff     = trial - {1'b0, divisor};
    q_bit    = (trial >= {1'b0, divisor});
    rem_next = q_bit ? diff[W-1:0] : trial[W-1:0];
  end

endmodule

// File: rtl/divider_32x16.sv
// Iterative unsigned 2*BIT / BIT divider with valid/ready handshakes.
// Define DIVIDER_RADIX4_EN to chain two steps per CALC cycle.
module divider_32x16
  import divider_pkg::*;
#(
  parameter int BIT = BIT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*BIT-1:0] dividend,
  input  logic [BIT-1:0]   divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BIT-1:0]   quotient,
  output logic [BIT-1:0]   remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int ITERS = iter_cnt(BIT);
  localparam int CW    = $clog2(ITERS) + 1;
  localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [BIT-1:0] rem;
  logic [BIT-1:0] quo;
  logic [BIT-1:0] lo;
  logic [BIT-1:0] dsr;
  logic           dbz;
  logic           ovf;

  logic [BIT-1:0] hi;
  logic [BIT-1:0] rem_n;
  logic [BIT-1:0] quo_n;
  logic [BIT-1:0] lo_n;
  logic [BIT-1:0] r0;
  logic           q0;

  assign hi = dividend[2*BIT-1:BIT];

  divider_step #(.W(BIT)) u_step0 (
    .rem      (rem),
    .din_bit  (lo[BIT-1]),
    .divisor  (dsr),
    .rem_next (r0),
    .q_bit    (q0)
  );

`ifdef DIVIDER_RADIX4_EN
  logic [BIT-1:0] r1;
  logic           q1;

  divider_step #(.W(BIT)) u_step1 (
    .rem      (r0),
    .din_bit  (lo[BIT-2]),
    .divisor  (dsr),
    .rem_next (r1),
    .q_bit    (q1)
  );

  assign rem_n = r1;
  assign quo_n = {quo[BIT-3:0], q0, q1};
  assign lo_n  = {lo[BIT-3:0], 2'b00};
`else
  assign rem_n = r0;
  assign quo_n = {quo[BIT-2:0], q0};
  assign lo_n  = {lo[BIT-2:0], 1'b0};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      rem   <= '0;
      quo   <= '0;
      lo    <= '0;
      dsr   <= '0;
      dbz   <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            lo  <= dividend[BIT-1:0];
            dsr <= divisor;
            cnt <= '0;
            if (divisor == '0) begin
              state <= DONE;
              dbz   <= 1'b1;
              ovf   <= 1'b0;
              quo   <= '1;
              rem   <= dividend[BIT-1:0];
            end else if (hi >= divisor) begin
              state <= DONE;
              dbz   <= 1'b0;
              ovf   <= 1'b1;
              quo   <= '1;
              rem   <= dividend[BIT-1:0];
            end else begin
              state <= CALC;
              dbz   <= 1'b0;
              ovf   <= 1'b0;
              quo   <= '0;
              rem   <= hi;
            end
          end
        end
        CALC: begin
          rem <= rem_n;
          quo <= quo_n;
          lo  <= lo_n;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready    = (state == IDLE);
  assign out_valid   = (state == DONE);
  assign quotient    = quo;
  assign remainder   = rem;
  assign div_by_zero = dbz;
  assign overflow    = ovf;

endmodule

// File: tb/tb_divider_32x16.sv
// Directed self-checking bench for divider_32x16.
module tb_divider_32x16;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;
  logic        overflow;

  int total = 0;
  int bad   = 0;
  int lat;
  int exp_lat;
  logic [15:0] q_hold;
  logic [15:0] r_hold;
  logic        seen;

  always #5 clk = ~clk;

  divider_32x16 dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op from IDLE and wait for out_valid; operands are scrambled after accept.
  task automatic issue(input logic [31:0] a, input logic [15:0] b,
                       output int l);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    tick();
    in_valid = 1'b0;
    dividend = 32'hDEAD_BEEF;
    divisor  = 16'h0003;
    l = 1;
    while (!out_valid && l < 40) begin
      tick();
      l++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic run(input string tag, input logic [31:0] a,
                     input logic [15:0] b, input logic [15:0] q,
                     input logic [15:0] r, input logic dz,
                     input logic ov);
    int l;
    issue(a, b, l);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_q"}, 32'(quotient), 32'(q));
    chk({tag, "_r"}, 32'(remainder), 32'(r));
    chk({tag, "_dbz"}, 32'(div_by_zero), 32'(dz));
    chk({tag, "_ovf"}, 32'(overflow), 32'(ov));
    consume();
    chk({tag, "_idle"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
`ifdef DIVIDER_RADIX4_EN
    exp_lat = 9;
`else
    exp_lat = 17;
`endif
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_q", 32'(quotient), 32'd0);
    chk("rst_r", 32'(remainder), 32'd0);
    chk("rst_flags", 32'({div_by_zero, overflow}), 32'd0);

    // Largest product, with latency check
    issue(32'hFFFE_0001, 16'hFFFF, lat);
    chk("max_lat", 32'(lat), 32'(exp_lat));
    chk("max_q", 32'(quotient), 32'h0000_FFFF);
    chk("max_r", 32'(remainder), 32'd0);
    chk("max_flags", 32'({div_by_zero, overflow}), 32'd0);
    consume();

    run("d1000_7", 32'd1000, 16'd7, 16'd142, 16'd6, 1'b0, 1'b0);
    run("d100_10", 32'd100, 16'd10, 16'd10, 16'd0, 1'b0, 1'b0);
    run("ffff_ffff", 32'h0000_FFFF, 16'hFFFF, 16'd1, 16'd0, 1'b0, 1'b0);
    run("ffff_100", 32'h0000_FFFF, 16'h0100, 16'h00FF, 16'h00FF, 1'b0, 1'b0);
    run("qmax", 32'h00FF_FFFF, 16'h0100, 16'hFFFF, 16'h00FF, 1'b0, 1'b0);

    // Divide by zero, one cycle latency
    issue(32'h1234_5678, 16'h0000, lat);
    chk("dbz_lat", 32'(lat), 32'd1);
    chk("dbz_flag", 32'(div_by_zero), 32'd1);
    chk("dbz_ovf", 32'(overflow), 32'd0);
    chk("dbz_q", 32'(quotient), 32'h0000_FFFF);
    chk("dbz_r", 32'(remainder), 32'h0000_5678);
    consume();

    // Overflow at the exact boundary hi == divisor
    issue(32'h0001_0000, 16'h0001, lat);
    chk("ovf_lat", 32'(lat), 32'd1);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_dbz", 32'(div_by_zero), 32'd0);
    chk("ovf_q", 32'(quotient), 32'h0000_FFFF);
    chk("ovf_r", 32'(remainder), 32'd0);
    consume();
    run("ovf2", 32'h0100_0000, 16'h0100, 16'hFFFF, 16'h0000, 1'b0, 1'b1);

    // Hold in DONE with a competing request pending
    issue(32'd1000, 16'd7, lat);
    q_hold   = quotient;
    r_hold   = remainder;
    in_valid = 1'b1;
    dividend = 32'd100;
    divisor  = 16'd10;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_q", 32'(quotient), 32'(q_hold));
      chk("hold_r", 32'(remainder), 32'(r_hold));
    end
    chk("hold_q_val", 32'(q_hold), 32'd142);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("rel_idle", 32'(in_ready), 32'd1);
    chk("rel_ov", 32'(out_valid), 32'd0);
    // Pending request is taken on this IDLE cycle
    tick();
    in_valid = 1'b0;
    chk("b2b_busy", 32'(in_ready), 32'd0);
    lat = 1;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk("b2b_lat", 32'(lat), 32'(exp_lat));
    chk("b2b_q", 32'(quotient), 32'd10);
    chk("b2b_r", 32'(remainder), 32'd0);
    consume();

    // Abort mid-calculation
    in_valid = 1'b1;
    dividend = 32'd1000;
    divisor  = 16'd7;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_idle", 32'(in_ready), 32'd1);
    chk("abort_ov", 32'(out_valid), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_result", 32'(seen), 32'd0);
    run("after_abort", 32'd1000, 16'd7, 16'd142, 16'd6, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/divider_32x16.md
DIVIDER_32X16 -- requirements
Module: divider_32x16

Interface
REQ-001 The block SHALL have parameter BIT, default 16, giving the divisor, quotient and remainder width; the dividend is 2*BIT wide.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  dividend/divisor present.
REQ-005 in_ready  output  1  block can accept an operation.
REQ-006 dividend  input  2*BIT  unsigned dividend (product-width operand).
REQ-007 divisor  input  BIT  unsigned divisor.
REQ-008 out_valid  output  1  result fields valid.
REQ-009 out_ready  input  1  consumer accepts result.
REQ-010 quotient  output  BIT  unsigned quotient.
REQ-011 remainder  output  BIT  unsigned remainder.
REQ-012 div_by_zero  output  1  divisor was zero.
REQ-013 overflow  output  1  quotient does not fit in BIT bits.

Function
REQ-014 The block SHALL implement states IDLE, CALC, DONE; in_ready = (state==IDLE), out_valid = (state==DONE).
REQ-015 Accept occurs on a cycle with in_valid && in_ready; operands SHALL be latched and later input changes ignored.
REQ-016 On accept with divisor==0: next state DONE, div_by_zero=1, overflow=0, quotient=all ones, remainder=dividend[BIT-1:0].
REQ-017 On accept with divisor!=0 and dividend[2*BIT-1:BIT] >= divisor: next state DONE, overflow=1, div_by_zero=0, quotient=all ones, remainder=dividend[BIT-1:0].
REQ-018 Otherwise next state CALC with iteration counter = 0 and partial remainder = dividend[2*BIT-1:BIT].
REQ-019 Each CALC cycle SHALL perform one restoring step: shift partial remainder left by one (BIT+1-bit trial, no truncation) bringing in the next dividend bit MSB-first, subtract divisor if trial >= divisor, shift the comparison result into quotient LSB.
REQ-020 After BIT CALC cycles the state SHALL be DONE; for accept at cycle N, out_valid rises at cycle N+BIT+1 (N+17 at default).
REQ-021 Results SHALL satisfy quotient*divisor + remainder == dividend and remainder < divisor whenever neither flag is set.
REQ-022 In DONE, all outputs SHALL hold stable until out_valid && out_ready; then state IDLE on the next cycle.
REQ-023 No new operation SHALL be accepted in the same cycle a result is consumed (in_ready low in DONE).

Reset
REQ-024 rst SHALL force state IDLE, clear counter, quotient, remainder, div_by_zero and overflow to 0, so in_ready=1, out_valid=0 on the cycle after rst.
REQ-025 rst asserted during CALC or DONE SHALL abandon the operation; no result is produced.

Configuration
REQ-026 With macro DIVIDER_RADIX4_EN defined, CALC SHALL retire two quotient bits per cycle (two chained restoring steps), taking BIT/2 cycles (out_valid at N+9 at default); BIT SHALL be even.
REQ-027 Without DIVIDER_RADIX4_EN, one bit per cycle per REQ-019; results identical in both builds.

Structure
REQ-028 Package divider_pkg SHALL hold BIT default, the state enum (IDLE, CALC, DONE) and the iteration count constant.
REQ-029 One restoring step SHALL be a combinational sub-module divider_step (inputs partial remainder, next dividend bit, divisor; outputs new remainder, quotient bit), instantiated once or twice per REQ-026/027.

Verification
REQ-030 dividend=0xFFFE0001, divisor=0xFFFF -> quotient=0xFFFF, remainder=0x0000, flags 0, out_valid exactly 17 cycles after accept (9 with radix-4).
REQ-031 dividend=1000, divisor=7 -> quotient=142, remainder=6.
REQ-032 dividend=0x12345678, divisor=0 -> div_by_zero=1, quotient=0xFFFF, remainder=0x5678, out_valid the cycle after accept.
REQ-033 dividend=0x00010000, divisor=0x0001 -> overflow=1, quotient=0xFFFF, remainder=0x0000.
REQ-034 out_ready held low 5 cycles in DONE -> outputs stable, in_ready=0; out_ready=1 -> IDLE next cycle; back-to-back valid inputs accepted only in IDLE.
REQ-035 rst pulsed at CALC iteration 8 -> IDLE next cycle, out_valid never asserted; following op 1000/7 returns 142 r 6.
